instr_prefetch_queue: RTL and testbench



---
 rtl/instr_prefetch_queue.sv | 129 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher feeding IF/ID through a DEPTH-entry in-order {pc, instr} queue.
// Latency: a response pushed at edge N is at the head in cycle N+1; redirect empties it at the next edge.
// Backpressure: out_ready low fills the queue; mem_req is withheld until a pop guarantees a free slot.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_WAIT_DISCARD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic          resp;
    logic          push;
    logic          pop;
    logic          space;
    logic [CW:0]   count_sum;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect needs no explicit arm: mem_req is already low, so WAIT without a
    // response falls into WAIT_DISCARD and every other case lands in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid)          state_d = mem_req ? ST_WAIT : ST_IDLE;
                else if (redirect_valid) state_d = ST_WAIT_DISCARD;
            end
            ST_WAIT_DISCARD: begin
                if (mem_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The slot check looks at the occupancy after this cycle's push/pop, so the
    // request issued now always has room for its response.
    always_comb begin
        resp      = (state_q == ST_WAIT) && mem_rvalid;
        push      = resp && !redirect_valid;
        out_valid = (count_q != '0);
        pop       = out_valid && out_ready && !redirect_valid;
        count_sum = {1'b0, count_q} + CW1'(push) - CW1'(pop);
        space     = count_sum < CW1'(DEPTH);
        mem_req   = rst_n && !redirect_valid && space && ((state_q == ST_IDLE) || resp);
        mem_addr  = resp ? fetch_pc_q + 32'd4 : fetch_pc_q;
        out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
        out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_sum[CW-1:0];
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            wr_ptr_d   = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: out_* are masked by count_q until a slot is written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: variable-latency memory model, stream-level scoreboard
// of the expected {pc, instr} sequence, and directed scenarios for reset, full, redirect and wrap.
module tb_instr_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    // memory model and stimulus knobs
    bit          busy, stale;
    int          lat_left;
    logic [31:0] pend_addr, pend_exp, exp_addr;
    int          lat_min = 1, lat_max = 1;
    int          ready_mode = 1;
    int          redir_pct  = 0;
    bit          force_redir;
    logic [31:0] force_tgt;

    // per-cycle snapshot of what the DUT showed
    logic        s_req, s_ov, s_rv;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic drive_inputs();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (busy) begin
            lat_left--;
            if (lat_left == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend_addr);
            end
        end
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_tgt;
            force_redir    = 1'b0;
        end else if ($urandom_range(99) < redir_pct) begin
            redirect_valid = 1'b1;
        end
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(1));
        endcase
    endtask

    // Stream-level model: expected output is the sequential run of words from
    // the last restart address, minus anything the consumer has taken.
    task automatic scoreboard_cycle();
        bit   rv, rd, good, pop, want_req, head_ok;
        int   after;
        ent_t e;
        s_req = mem_req; s_addr = mem_addr; s_ov = out_valid;
        s_pc = out_pc; s_instr = out_instr; s_rv = mem_rvalid;
        rv = mem_rvalid;
        rd = redirect_valid;

        n_checks++;
        if (out_valid !== (exp_q.size() != 0))
            $display("FAIL sb_out_valid cyc=%0d: got %b want %0d", cyc, out_valid, exp_q.size() != 0);
        else n_pass++;
        if (exp_q.size() != 0) begin
            head_ok = (out_pc === exp_q[0].pc) && (out_instr === exp_q[0].instr);
            n_checks++;
            if (!head_ok)
                $display("FAIL sb_head cyc=%0d: got pc=%h instr=%h want pc=%h instr=%h",
                         cyc, out_pc, out_instr, exp_q[0].pc, exp_q[0].instr);
            else n_pass++;
        end else begin
            n_checks++;
            if (out_pc !== 32'h0 || out_instr !== 32'h0)
                $display("FAIL sb_empty_zero cyc=%0d: got pc=%h instr=%h want 0/0", cyc, out_pc, out_instr);
            else n_pass++;
        end

        good     = rv && busy && !stale && !rd;
        pop      = (exp_q.size() != 0) && (out_ready === 1'b1) && !rd;
        after    = exp_q.size() + int'(good) - int'(pop);
        want_req = !rd && (!busy || (rv && !stale)) && (after < DEPTH);
        n_checks++;
        if (mem_req !== want_req)
            $display("FAIL sb_mem_req cyc=%0d: got %b want %b", cyc, mem_req, want_req);
        else n_pass++;
        if (mem_req === 1'b1 && want_req) begin
            n_checks++;
            if (mem_addr !== exp_addr)
                $display("FAIL sb_mem_addr cyc=%0d: got %h want %h", cyc, mem_addr, exp_addr);
            else n_pass++;
        end

        if (pop) void'(exp_q.pop_front());
        if (good) begin
            e.pc    = pend_exp;
            e.instr = mem_word(pend_exp);
            exp_q.push_back(e);
        end
        if (rv && busy) begin
            busy  = 1'b0;
            stale = 1'b0;
        end
        if (rd) begin
            exp_q.delete();
            exp_addr = redirect_pc & 32'hFFFF_FFFC;
            if (busy) stale = 1'b1;
        end
        if (mem_req === 1'b1) begin
            busy      = 1'b1;
            stale     = 1'b0;
            lat_left  = $urandom_range(lat_max, lat_min);
            pend_addr = mem_addr;
            pend_exp  = exp_addr;
            exp_addr  = exp_addr + 32'd4;
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk); #1;
        drive_inputs();
        @(negedge clk);
        scoreboard_cycle();
    endtask

    task automatic model_reset();
        busy = 1'b0; stale = 1'b0; force_redir = 1'b0;
        exp_q.delete();
        exp_addr = RESET_PC;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; mem_rvalid = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    task automatic release_step();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_inputs();
        @(negedge clk);
        scoreboard_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        n_checks++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0) $display("FAIL reset_ctrl: mem_req=%b out_valid=%b want 0/0", mem_req, out_valid);
        else n_pass++;
        n_checks++;
        if (out_pc !== 32'h0 || out_instr !== 32'h0) $display("FAIL reset_data: pc=%h instr=%h want 0/0", out_pc, out_instr);
        else n_pass++;
        model_reset();
        lat_min = 1; lat_max = 1; ready_mode = 1; redir_pct = 0;
        repeat (2) @(posedge clk);
        release_step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== RESET_PC) $display("FAIL reset_first_req: req=%b addr=%h want 1/%h", s_req, s_addr, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_sequential();
        lat_min = 1; lat_max = 1; ready_mode = 1; redir_pct = 0;
        apply_reset();
        release_step();
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step();
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== 32'(4 * k)) $display("FAIL seq_addr k=%0d: req=%b addr=%h want 1/%h", k, s_req, s_addr, 32'(4 * k));
            else n_pass++;
            n_checks++;
            if (s_ov !== (k >= 2)) $display("FAIL seq_valid k=%0d: got %b want %0d", k, s_ov, k >= 2);
            else n_pass++;
            if (k >= 2) begin
                n_checks++;
                if (s_pc !== 32'(4 * (k - 2))) $display("FAIL seq_pc k=%0d: got %h want %h", k, s_pc, 32'(4 * (k - 2)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int          nreq;
        logic [31:0] addrs[$];
        lat_min = 1; lat_max = 1; ready_mode = 0; redir_pct = 0;
        apply_reset();
        release_step();
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            if (s_req === 1'b1) begin nreq++; addrs.push_back(s_addr); end
        end
        n_checks++;
        if (nreq != DEPTH || s_req !== 1'b0) $display("FAIL full_reqs: got %0d reqs, last req=%b want %0d/0", nreq, s_req, DEPTH);
        else n_pass++;
        for (int i = 0; i < addrs.size() && i < DEPTH; i++) begin
            n_checks++;
            if (addrs[i] !== 32'(4 * i)) $display("FAIL full_addr%0d: got %h want %h", i, addrs[i], 32'(4 * i));
            else n_pass++;
        end
        ready_mode = 1;
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h10 || s_pc !== 32'h0) $display("FAIL drain_first: req=%b addr=%h pc=%h want 1/10/0", s_req, s_addr, s_pc);
        else n_pass++;
        for (int k = 1; k < DEPTH; k++) begin
            step();
            n_checks++;
            if (s_ov !== 1'b1 || s_pc !== 32'(4 * k)) $display("FAIL drain_pc%0d: valid=%b pc=%h want 1/%h", k, s_ov, s_pc, 32'(4 * k));
            else n_pass++;
        end
    endtask

    task automatic test_redirect_outstanding();
        bit found;
        lat_min = 3; lat_max = 3; ready_mode = 1; redir_pct = 0;
        apply_reset();
        release_step();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (s_req === 1'b1 && s_addr === 32'h8) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL redir_wait_req8: got no request to 8 within 40 cycles want one");
        else n_pass++;
        force_redir = 1'b1; force_tgt = 32'h100;
        step();
        n_checks++;
        if (s_req !== 1'b0 || s_ov !== 1'b1) $display("FAIL redir_cycle: req=%b valid=%b want 0/1", s_req, s_ov);
        else n_pass++;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (s_req === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found || s_addr !== 32'h100) $display("FAIL redir_new_req: found=%0d addr=%h want 1/100", found, s_addr);
        else n_pass++;
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_ov === 1'b1) begin
                n_checks++;
                if (s_pc < 32'h100) $display("FAIL redir_wrong_path: pc=%h want >=100", s_pc);
                else n_pass++;
            end
        end
    endtask

    task automatic test_redirect_with_rvalid();
        lat_min = 1; lat_max = 1; ready_mode = 1; redir_pct = 0;
        apply_reset();
        release_step();
        repeat (3) step();
        force_redir = 1'b1; force_tgt = 32'h200;
        step();
        n_checks++;
        if (s_req !== 1'b0) $display("FAIL redir_rv_cycle: req=%b want 0", s_req);
        else n_pass++;
        step();
        n_checks++;
        if (s_ov !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h200)
            $display("FAIL redir_rv_next: valid=%b req=%b addr=%h want 0/1/200", s_ov, s_req, s_addr);
        else n_pass++;
        step(); step();
        n_checks++;
        if (s_ov !== 1'b1 || s_pc !== 32'h200) $display("FAIL redir_rv_head: valid=%b pc=%h want 1/200", s_ov, s_pc);
        else n_pass++;
    endtask

    task automatic test_wrap();
        lat_min = 1; lat_max = 1; ready_mode = 1; redir_pct = 0;
        apply_reset();
        release_step();
        repeat (2) step();
        force_redir = 1'b1; force_tgt = 32'hFFFF_FFFE;
        step();
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req0: req=%b addr=%h want 1/fffffffc", s_req, s_addr);
        else n_pass++;
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL wrap_req1: req=%b addr=%h want 1/0", s_req, s_addr);
        else n_pass++;
        step();
        n_checks++;
        if (s_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0: got %h want fffffffc", s_pc);
        else n_pass++;
        step();
        n_checks++;
        if (s_pc !== 32'h0) $display("FAIL wrap_pc1: got %h want 0", s_pc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        lat_min = 1; lat_max = 1; ready_mode = 0; redir_pct = 0;
        apply_reset();
        release_step();
        repeat (2) step();
        @(posedge clk); #1;
        rst_n = 1'b0; mem_rvalid = 1'b0; redirect_valid = 1'b0;
        #2;
        n_checks++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0)
            $display("FAIL midreset_outs: req=%b valid=%b pc=%h instr=%h want all 0", mem_req, out_valid, out_pc, out_instr);
        else n_pass++;
        model_reset();
        ready_mode = 1;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        scoreboard_cycle();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== RESET_PC) $display("FAIL midreset_restart: req=%b addr=%h want 1/%h", s_req, s_addr, RESET_PC);
        else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (s_ov === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || s_pc !== RESET_PC || s_instr !== mem_word(RESET_PC))
            $display("FAIL midreset_first_out: seen=%0d pc=%h instr=%h want 1/%h/%h", seen, s_pc, s_instr, RESET_PC, mem_word(RESET_PC));
        else n_pass++;
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 4; ready_mode = 2; redir_pct = 4;
        apply_reset();
        release_step();
        repeat (3000) step();
        redir_pct = 0; ready_mode = 1;
        repeat (20) step();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_with_rvalid();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
